serial_frame_tx: RTL and testbench

Serial frame transmitter that serializes a parallel word onto a single-bit line: idle-high, one start bit (0), DATA_W data bits LSB first, an optional even-parity bit, and one stop bit (1). It drives the serial input of the lab serial-decoder FSMs and the Basys3 UART TX pin. It sits between a parallel producer (MCU output port or switch bank) and the serial consumer, using a start/busy/done handshake.

---
 rtl/serial_frame_tx_if.sv | 14 +
 rtl/serial_frame_tx.sv | 144 ++++++++++++++
 tb/tb_serial_frame_tx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-line bundle for serial_frame_tx.
// The producer side uses the master modport and the transmitter uses the slave modport.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              tx_out;
    logic              busy;
    logic              done;

    modport master (output start, output data_in, input tx_out, input busy, input done);
    modport slave  (input start, input data_in, output tx_out, output busy, output done);
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter. The line idles high. Each frame is a start bit (0),
// then DATA_W data bits LSB first, then an optional even-parity bit, then a stop bit (1).
// Every bit is held for CLKS_PER_BIT clocks.
// Define PARITY_EN to compile in the parity bit. Without it, STOP follows DATA directly.
// All outputs are registered. Each output's next value is derived from the next state,
// so a frame becomes visible on the edge that accepts it.
module serial_frame_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    serial_frame_tx_if.slave bus
);
    localparam int BW_RAW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW     = (BW_RAW < 1) ? 1 : BW_RAW;
    localparam int IW_RAW = $clog2(DATA_W + 1);
    localparam int IW     = (IW_RAW < 1) ? 1 : IW_RAW;

    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_MAX  = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state, state_nxt;
    logic [BW-1:0]     baud_cnt, baud_nxt;
    logic [IW-1:0]     bit_idx, bit_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic              tx_r, tx_nxt;
    logic              busy_r, busy_nxt;
    logic              done_r, done_nxt;
    logic              bit_end;
`ifdef PARITY_EN
    // The parity bit is latched at acceptance, because the shift register is consumed as bits go out.
    logic              par_r, par_nxt;
`endif

    assign bit_end     = (baud_cnt == BAUD_MAX);
    assign bus.tx_out  = tx_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;

    // State, counters and registered outputs. Reset aborts any frame and forces the line high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef PARITY_EN
            par_r    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            tx_r     <= tx_nxt;
            busy_r   <= busy_nxt;
            done_r   <= done_nxt;
`ifdef PARITY_EN
            par_r    <= par_nxt;
`endif
        end
    end

    // Next-state logic, then the output values that belong to that next state.
    always_comb begin
        state_nxt = state;
        baud_nxt  = bit_end ? '0 : baud_cnt + 1'b1;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        done_nxt  = 1'b0;
`ifdef PARITY_EN
        par_nxt   = par_r;
`endif
        case (state)
            IDLE: begin
                baud_nxt = '0;
                bit_nxt  = '0;
                if (bus.start) begin
                    state_nxt = START;
                    shift_nxt = bus.data_in;
`ifdef PARITY_EN
                    par_nxt   = ^bus.data_in;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift >> 1;
                    if (bit_idx == BIT_MAX) begin
`ifdef PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_idx + 1'b1;
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
`ifdef PARITY_EN
            PARITY:  tx_nxt = par_nxt;
`endif
            default: tx_nxt = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx. A frame-level model builds each expected line waveform
// from the data word and checks the main instance on every cycle. Directed literal checks
// pin down the model, and a second instance covers the 1-clock, 1-bit corner.
module tb_serial_frame_tx;
    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef PARITY_EN
    localparam int PAR = 1;
    localparam int LIT_FRAME = 44;
`else
    localparam int PAR = 0;
    localparam int LIT_FRAME = 40;
`endif
    localparam int NBITS   = DW + 2 + PAR;
    localparam int FRAME   = NBITS * CPB;
    localparam int E_FRAME = 3 + PAR;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_frame_tx_if #(.DATA_W(DW)) bus ();
    serial_frame_tx_if #(.DATA_W(1))  ebus ();

    serial_frame_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave));
    serial_frame_tx #(.CLKS_PER_BIT(1), .DATA_W(1)) edut (
        .clk(clk), .reset_n(reset_n), .bus(ebus.slave));

    // Expected line level on each clock of a frame, built from the framing rules.
    function automatic logic [FRAME-1:0] frame_wave(input logic [DW-1:0] d);
        logic [FRAME-1:0] w;
        int k;
        for (int i = 0; i < FRAME; i++) begin
            k = i / CPB;
            if (k == 0)                        w[i] = 1'b0;
            else if (k <= DW)                  w[i] = d[k-1];
            else if (PAR == 1 && k == DW + 1)  w[i] = ^d;
            else                               w[i] = 1'b1;
        end
        return w;
    endfunction

    logic [FRAME-1:0] m_wave;
    int               m_pos;
    logic             m_act, m_done;
    logic             exp_tx, exp_busy, exp_done;

    // Frame-level model: an idle line accepts start, then plays back the waveform for FRAME cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_act  <= 1'b0;
            m_pos  <= 0;
            m_done <= 1'b0;
            m_wave <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_act) begin
                if (m_pos == FRAME - 1) begin
                    m_act  <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_pos <= m_pos + 1;
                end
            end else if (bus.start) begin
                m_wave <= frame_wave(bus.data_in);
                m_pos  <= 0;
                m_act  <= 1'b1;
            end
        end
    end

    assign exp_tx   = m_act ? m_wave[m_pos] : 1'b1;
    assign exp_busy = m_act;
    assign exp_done = m_done;

    // Every cycle, compare the main instance against the model.
    always @(negedge clk) begin
        checks++;
        if (bus.tx_out !== exp_tx || bus.busy !== exp_busy || bus.done !== exp_done) begin
            errors++;
            $display("FAIL model t=%0t tx=%b req %b busy=%b req %b done=%b req %b",
                     $time, bus.tx_out, exp_tx, bus.busy, exp_busy, bus.done, exp_done);
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    logic s_tx [0:FRAME+3];
    int   s_busy, s_done_n, s_done_at;

    // Send one word and record the line for the whole frame. The first sample is bit 0, cycle 0.
    // With poke set, a start carrying all-ones is pulsed in the middle of the frame.
    task automatic run_frame(input logic [DW-1:0] d, input bit poke);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = d;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.data_in = ~d;
        s_busy = 0; s_done_n = 0; s_done_at = -1;
        for (int i = 0; i < FRAME + 4; i++) begin
            if (i > 0) @(negedge clk);
            if (poke && i == 12) begin bus.start = 1'b1; bus.data_in = '1; end
            if (poke && i == 13) bus.start = 1'b0;
            s_tx[i] = bus.tx_out;
            if (bus.busy) s_busy++;
            if (bus.done) begin s_done_n++; s_done_at = i; end
        end
    endtask

    function automatic int bit_at(input int k);
        return int'(s_tx[k * CPB + CPB / 2]);
    endfunction

    int t, d1, d2, nb, nd;
    logic [NBITS-1:0] lit_a5;

    initial begin
        bus.start = 1'b0; bus.data_in = '0;
        ebus.start = 1'b0; ebus.data_in = '0;
`ifdef PARITY_EN
        lit_a5 = 11'b1_0_10100101_0;
`else
        lit_a5 = 10'b1_10100101_0;
`endif
        repeat (3) @(negedge clk);
        check("reset tx", int'(bus.tx_out), 1);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // The A5 frame, compared bit by bit against a hand-written pattern.
        run_frame(8'hA5, 1'b0);
        for (int k = 0; k < NBITS; k++) check($sformatf("a5 bit%0d", k), bit_at(k), int'(lit_a5[k]));
        check("a5 busy cycles", s_busy, LIT_FRAME);
        check("a5 done count", s_done_n, 1);
        check("a5 done cycle", s_done_at, LIT_FRAME);

`ifdef PARITY_EN
        run_frame(8'h07, 1'b0);
        check("parity 07", bit_at(DW + 1), 1);
        check("len 07", s_busy, 44);
        run_frame(8'h03, 1'b0);
        check("parity 03", bit_at(DW + 1), 0);
`endif

        // A start pulse mid-frame must not change the frame in flight or queue another frame.
        run_frame(8'h3C, 1'b1);
        check("ign done count", s_done_n, 1);
        check("ign bit2", bit_at(3), 1);
        nb = 0;
        repeat (2 * FRAME) begin @(negedge clk); if (bus.busy) nb++; end
        check("ign no second frame", nb, 0);

        // Back-to-back: start is held high, and the word changes to all-ones in the done cycle.
        // The two done pulses are FRAME+1 edges apart, with FRAME cycles between them.
        @(negedge clk);
        bus.start = 1'b1; bus.data_in = 8'h00;
        t = 0; d1 = -1; d2 = -1;
        while (t < 4 * FRAME && d2 < 0) begin
            @(negedge clk); t++;
            if (d1 >= 0 && t == d1 + 1) begin
                check("b2b start bit", int'(bus.tx_out), 0);
                check("b2b busy", int'(bus.busy), 1);
                bus.start = 1'b0;
            end
            if (bus.done) begin
                if (d1 < 0) begin d1 = t; bus.data_in = 8'hFF; end
                else d2 = t;
            end
        end
        bus.start = 1'b0;
        check("b2b done gap", d2 - d1, LIT_FRAME + 1);
        repeat (4) @(negedge clk);

        // Reset asserted in the middle of the data bits.
        @(negedge clk); bus.start = 1'b1; bus.data_in = 8'h5A;
        @(negedge clk); bus.start = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("pre-reset busy", int'(bus.busy), 1);
        @(posedge clk); #1 reset_n = 1'b0; #1;
        check("abort tx", int'(bus.tx_out), 1);
        check("abort busy", int'(bus.busy), 0);
        check("abort done", int'(bus.done), 0);
        @(negedge clk); reset_n = 1'b1;
        nb = 0; nd = 0;
        repeat (2 * FRAME) begin @(negedge clk); if (bus.busy) nb++; if (bus.done) nd++; end
        check("post-reset busy", nb, 0);
        check("post-reset done", nd, 0);

        // Corner case: one clock per bit and a single data bit.
        @(negedge clk); ebus.start = 1'b1; ebus.data_in = 1'b1;
        @(negedge clk); ebus.start = 1'b0; ebus.data_in = 1'b0;
        nb = 0;
        for (int i = 0; i < E_FRAME + 1; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) check("edge tx0", int'(ebus.tx_out), 0);
            if (i == 1) check("edge tx1", int'(ebus.tx_out), 1);
            if (i == 2) check("edge tx2", int'(ebus.tx_out), 1);
            if (i == E_FRAME) check("edge done", int'(ebus.done), 1);
            if (ebus.busy) nb++;
        end
        check("edge busy cycles", nb, E_FRAME);

        // Random traffic: start and data change every cycle, and the model judges each cycle.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            bus.start   = ($urandom_range(0, 3) == 0);
            bus.data_in = DW'($urandom);
        end
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (FRAME + 5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
